mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 89 ++++++++
 tb/tb_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Brief    : Data-memory responder with a fixed per-request wait latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rnw,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        status,
  output logic        error,
  output logic [31:0] rdata
);

  localparam int unsigned c_AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  c_LAT = 4'(LATENCY);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_WAIT = 2'd1;
  localparam logic [1:0] c_S_RESP = 2'd2;

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic            r_rnw;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic [31:0]     w_offset;
  logic [c_AW-1:0] w_index;
  logic            w_fault;
  logic            w_resp;

  // BASE_ADDR is DEPTH-aligned, so the offset's low bits equal the address's.
  assign w_offset = r_addr - BASE_ADDR;
  assign w_index  = w_offset[c_AW+1:2];
  assign w_fault  = (w_offset[1:0] != 2'b00) || (w_offset[31:c_AW+2] != '0);
  assign w_resp   = (r_state == c_S_RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (enable) begin
            r_rnw   <= rnw;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= c_LAT;
            r_state <= (c_LAT != 4'd0) ? c_S_WAIT : c_S_RESP;
          end
        end
        c_S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= c_S_RESP;
          end
        end
        c_S_RESP: r_state <= c_S_IDLE;
        default:  r_state <= c_S_IDLE;
      endcase
    end
  end

  // Storage is deliberately left out of reset; a reset in RESP cancels the commit.
  always_ff @(posedge clk) begin
    if (!reset && w_resp && !r_rnw && !w_fault) begin
      r_mem[w_index] <= r_wdata;
    end
  end

  assign status = w_resp;
  assign error  = w_resp && w_fault;
  assign rdata  = (w_resp && r_rnw && !w_fault) ? r_mem[w_index] : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Self-checking bench for mem_responder (LATENCY 2 and LATENCY 0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, rnw;
  logic [31:0] addr, wdata;
  logic        status, error;
  logic [31:0] rdata;

  logic        en0, rnw0;
  logic [31:0] addr0, wdata0;
  logic        status0, error0;
  logic [31:0] rdata0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_mem [DEPTH];
  int          known_idx[$];

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .rnw(rnw), .addr(addr),
    .wdata(wdata), .status(status), .error(error), .rdata(rdata)
  );

  mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .enable(en0), .rnw(rnw0), .addr(addr0),
    .wdata(wdata0), .status(status0), .error(error0), .rdata(rdata0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off >> 2);
  endfunction

  // Issue one request, scramble the inputs while it is pending, check every cycle.
  task automatic do_req(input string tag, input logic r, input logic [31:0] a,
                        input logic [31:0] d);
    bit          f;
    int          idx;
    logic [31:0] exp_rd;
    f      = m_fault(a);
    idx    = m_idx(a);
    exp_rd = (r && !f) ? m_mem[idx] : 32'd0;
    @(negedge clk);
    enable = 1'b1; rnw = r; addr = a; wdata = d;
    @(posedge clk);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      chk({tag, ":status"}, {31'd0, status}, 32'(c == LAT + 1));
      if (c <= LAT) begin
        enable = 1'($urandom); rnw = 1'($urandom);
        addr   = $urandom;     wdata = $urandom;
      end else begin
        chk({tag, ":error"}, {31'd0, error}, {31'd0, f});
        chk({tag, ":rdata"}, rdata, exp_rd);
        enable = 1'b0;
      end
    end
    if (!r && !f) begin
      if (m_mem[idx] === 32'hxxxx_xxxx) known_idx.push_back(idx);
      m_mem[idx] = d;
    end
    @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hxxxx_xxxx;
    reset = 1'b1; enable = 1'b0; rnw = 1'b0; addr = 32'd0; wdata = 32'd0;
    en0 = 1'b0; rnw0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst:status", {31'd0, status}, 32'd0);
    chk("rst:error",  {31'd0, error},  32'd0);
    chk("rst:rdata",  rdata,           32'd0);
    chk("rst0:status", {31'd0, status0}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) do_req("init", 1'b0, BASE + 32'(i * 4), $urandom);
    do_req("init_top", 1'b0, BASE + 32'h0FFC, 32'h1234_5678);

    do_req("wr_beef", 1'b0, BASE + 32'h10, 32'hDEAD_BEEF);
    do_req("rd_beef", 1'b1, BASE + 32'h10, 32'd0);

    do_req("rd_misalign", 1'b1, BASE + 32'h2, 32'd0);
    do_req("rd_above",    1'b1, BASE + 32'h1000, 32'd0);
    do_req("rd_below",    1'b1, 32'h7FFF_FFFC, 32'd0);
    do_req("wr_above",    1'b0, BASE + 32'h1000, 32'hBAD0_0001);
    do_req("wr_misalign", 1'b0, BASE + 32'h13, 32'hBAD0_0002);
    do_req("rd_keep",     1'b1, BASE + 32'h10, 32'd0);

    do_req("wr_top", 1'b0, BASE + 32'h0FFC, 32'hCAFE_F00D);
    do_req("rd_top", 1'b1, BASE + 32'h0FFC, 32'd0);

    // Reset while a write to word 8 sits in WAIT; a write held on the inputs must lose to reset.
    @(negedge clk);
    enable = 1'b1; rnw = 1'b0; addr = BASE + 32'h20; wdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1; addr = BASE + 32'h4; wdata = 32'h6666_7777;
    chk("rstwait:status_wait", {31'd0, status}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rstwait:status_rst", {31'd0, status}, 32'd0);
    end
    reset = 1'b0; enable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rstwait:status_after", {31'd0, status}, 32'd0);
    end
    do_req("rstwait:rd20", 1'b1, BASE + 32'h20, 32'd0);
    do_req("rstwait:rd04", 1'b1, BASE + 32'h4, 32'd0);

    // LATENCY=0: write then immediate read of the same word with enable held high.
    @(negedge clk);
    en0 = 1'b1; rnw0 = 1'b0; addr0 = BASE + 32'h4; wdata0 = 32'hA5A5_0F0F;
    @(negedge clk);
    chk("l0:wr_status", {31'd0, status0}, 32'd1);
    chk("l0:wr_error",  {31'd0, error0},  32'd0);
    rnw0 = 1'b1;
    @(negedge clk);
    chk("l0:gap_status", {31'd0, status0}, 32'd0);
    @(negedge clk);
    chk("l0:rd_status", {31'd0, status0}, 32'd1);
    chk("l0:rd_data",   rdata0,           32'hA5A5_0F0F);
    // Back-to-back faulting reads: one strobe every second cycle.
    addr0 = BASE + 32'h1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("l0:b2b_status", {31'd0, status0}, 32'(k % 2 == 1));
      chk("l0:b2b_error",  {31'd0, error0},  32'(k % 2 == 1));
      chk("l0:b2b_rdata",  rdata0,           32'd0);
    end
    en0 = 1'b0;

    for (int n = 0; n < 60; n++) begin
      int          sel;
      logic [31:0] a;
      sel = int'($urandom_range(0, 9));
      if (sel <= 5) begin
        a = BASE + 32'(known_idx[$urandom_range(0, known_idx.size() - 1)] * 4);
        do_req("rnd:rd", 1'b1, a, 32'd0);
      end else if (sel <= 7) begin
        a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
        do_req("rnd:wr", 1'b0, a, $urandom);
      end else begin
        case ($urandom_range(0, 2))
          0:       a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4) + 32'($urandom_range(1, 3));
          1:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 4095) * 4);
          default: a = BASE - 32'($urandom_range(1, 4096) * 4);
        endcase
        do_req("rnd:fault", 1'($urandom), a, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
